wb_lsu_master: RTL and testbench
================================

# wb_lsu_master

Load/store unit bus master that turns single CPU memory requests (RV32 LB/LH/LW/LBU/LHU/SB/SH/SW) into one Wishbone transfer towards the data RAM and other slaves. It returns the sign- or zero-extended load result to the CPU. It sits between the CPU execute/memory stage and the Wishbone bus.

## Interface
- TIMEOUT_CYCLES, 16: maximum wait cycles for a read ack. Used only when the timeout feature is compiled in.
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  CPU request strobe.
- req_ready  out  1  high only in IDLE. A request is accepted when req_valid and req_ready are both high.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3 of the load/store.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, unshifted, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse. There is no backpressure.
- resp_err  out  1  misaligned access, illegal funct3, or timeout. Qualified by resp_valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- wb_cyc, wb_stb, wb_we  out  1 each  Wishbone controls.
- wb_sel  out  4  byte lanes.
- wb_adr  out  32  byte address, equal to req_addr.
- wb_dat_o  out  32  store data, passed through unshifted (slaves shift by adr[1:0]).
- wb_dat_i  in  32  read data, already right-aligned by the slave using adr[1:0].
- wb_ack  in  1  read acknowledge.

## Operation
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000, 001, 010. Any other funct3 is an error.
- Misalignment rules: halfword with addr[0]=1 is misaligned; word with addr[1:0]≠0 is misaligned. Errors issue no bus cycle.
- wb_sel encoding:
  - byte: 4'b0001 << addr[1:0]
  - halfword: 4'b0011 if addr[1]=0, else 4'b1100
  - word: 4'b1111
- Load extension, applied to wb_dat_i:
  - LB: sign-extend [7:0]
  - LBU: zero-extend [7:0]
  - LH: sign-extend [15:0]
  - LHU: zero-extend [15:0]
  - LW: as is
- Slaves never ack writes. A write completes in its single cyc&stb cycle.
- Reads use a one-cycle stb pulse. cyc, adr and sel are then held until wb_ack, because the slave's output alignment is combinational on adr.
- FSM states:
  - IDLE: on accept, go to ERR if the request is illegal, else STROBE.
  - STROBE: cyc=stb=1, with we/sel/adr/dat registered. Store goes to DONE; load goes to WAIT.
  - WAIT: cyc=1, stb=0. On wb_ack, capture the extended data and go to DONE. On timeout, go to ERR.
  - DONE: resp_valid=1, err=0, then IDLE.
  - ERR: resp_valid=1, err=1, rdata=0, then IDLE.
- wb_ack outside WAIT is ignored.

## Timing
- Reset values: all outputs 0 except req_ready=1. State is IDLE.
- Request accepted in cycle T. STROBE is T+1.
- Store: resp_valid at T+2.
- Load, with the RAM acking in the cycle after stb: ack at T+2, resp_valid at T+3. Each extra wait cycle adds 1.
- Error from illegal request: resp_valid err=1 at T+1. wb_cyc stays 0.
- Next request can be accepted in the cycle after resp_valid (IDLE).
- Reset mid-transfer: at the next edge with rst_n=0, cyc/stb drop, no resp_valid is issued, and the FSM returns to IDLE.

## Configuration
- WB_LSU_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT. It is cleared on entry to WAIT. After TIMEOUT_CYCLES cycles without ack, the FSM enters ERR and drops cyc.
- Not defined: WAIT lasts indefinitely until ack. There is no counter logic.

## Structure
- lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum (IDLE, STROBE, WAIT, DONE, ERR)
  - a sel-encoding function
- Sub-module lsu_load_extend is purely combinational: funct3 plus wb_dat_i in, 32-bit extended data out.

## Test plan
- SW addr 0x10, data 0xDEADBEEF → at T+1, sel=4'b1111, adr=0x10, dat_o=0xDEADBEEF, stb high for exactly 1 cycle. resp_valid err=0 at T+2.
- SB addr 0x13, data 0xA5 → sel=4'b1000. Then LBU 0x13 gives rdata=0x000000A5, and LB 0x13 gives 0xFFFFFFA5, each at T+3.
- Preload word 0x8001_1234 at 0x10. LH 0x12 gives 0xFFFF8001, LHU 0x12 gives 0x00008001, and sel=4'b1100 is held through ack.
- LW 0x06 → resp_valid err=1 at T+1, rdata=0, wb_cyc never high. Illegal funct3 011 gives the same response.
- WB_LSU_TIMEOUT_EN with TIMEOUT_CYCLES=16 and ack tied low → err=1 after 16 WAIT cycles, cyc low afterwards. A late ack is ignored.
- rst_n low during WAIT → cyc=0 and req_ready=1 after the edge, with no resp_valid pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and helpers shared by the Wishbone load/store master
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, STROBE, WAIT, DONE, ERR} state_t;
  function automatic logic [3:0] sel_enc(input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == 2'b00 ? 4'b0001 << a : f3[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    return f3[1:0] == 2'b11 || (f3[2] && (we || f3[1])) ||
           (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: sign/zero extension of right-aligned Wishbone read data by funct3
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] ext_data
);
  always_comb
    ext_data = funct3 == F3_B  ? {{24{wb_dat_i[7]}}, wb_dat_i[7:0]} :
               funct3 == F3_BU ? {24'h0, wb_dat_i[7:0]} :
               funct3 == F3_H  ? {{16{wb_dat_i[15]}}, wb_dat_i[15:0]} :
               funct3 == F3_HU ? {16'h0, wb_dat_i[15:0]} : wb_dat_i;
endmodule

// File: rtl/wb_lsu_master.sv
// wb_lsu_master: single-request RV32 load/store to Wishbone master; WB_LSU_TIMEOUT_EN adds a read-ack timeout
module wb_lsu_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack
);
  state_t state, nxt;
  logic [2:0] f3_q;
  logic [31:0] rdata_q, ext;
  logic tmo;
  lsu_load_extend u_ext (.funct3(f3_q), .wb_dat_i(wb_dat_i), .ext_data(ext));
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q     <= '0;
      wb_we    <= 1'b0;
      wb_sel   <= '0;
      wb_adr   <= '0;
      wb_dat_o <= '0;
      rdata_q  <= '0;
    end else begin
      if (req_valid && req_ready) begin
        f3_q     <= req_funct3;
        wb_we    <= req_we;
        wb_sel   <= sel_enc(req_funct3, req_addr[1:0]);
        wb_adr   <= req_addr;
        wb_dat_o <= req_wdata;
      end
      if (state == WAIT && wb_ack) rdata_q <= ext;
    end
  end
`ifdef WB_LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!rst_n || state != WAIT) ? '0 : cnt + 1'b1;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state == IDLE   ? (req_valid ? (req_illegal(req_we, req_funct3, req_addr[1:0]) ? ERR : STROBE) : IDLE) :
          state == STROBE ? (wb_we ? DONE : WAIT) :
          state == WAIT   ? (wb_ack ? DONE : tmo ? ERR : WAIT) : IDLE;
    req_ready  = state == IDLE;
    wb_cyc     = state == STROBE || state == WAIT;
    wb_stb     = state == STROBE;
    resp_valid = state == DONE || state == ERR;
    resp_err   = state == ERR;
    resp_rdata = (state == DONE && !wb_we) ? rdata_q : '0;
  end
endmodule

// File: tb/tb_wb_lsu_master.sv
// tb_wb_lsu_master: directed and random load/store checks against a byte-array memory model
module tb_wb_lsu_master;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_we = 0, req_ready;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic wb_cyc, wb_stb, wb_we, wb_ack = 0;
  logic [3:0] wb_sel;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i, junk = 0, rd_word, wsh, got;
  logic [7:0] ram [256];
  logic [7:0] mem [256];
  int n_vec = 0, n_err = 0;

  wb_lsu_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack));

  always #5 clk = ~clk;

  // slave RAM: stores shift data by adr[1:0], reads return right-aligned data
  assign wsh = wb_dat_o << {wb_adr[1:0], 3'b000};
  assign rd_word = {ram[{wb_adr[7:2], 2'd3}], ram[{wb_adr[7:2], 2'd2}], ram[{wb_adr[7:2], 2'd1}], ram[{wb_adr[7:2], 2'd0}]};
  assign wb_dat_i = wb_ack ? rd_word >> {wb_adr[1:0], 3'b000} : junk;
  always @(posedge clk)
    if (wb_cyc && wb_stb && wb_we)
      for (int i = 0; i < 4; i++)
        if (wb_sel[i]) ram[{wb_adr[7:2], 2'(i)}] <= wsh[8*i +: 8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] b0, b1;
    b0 = mem[a[7:0]];
    b1 = mem[a[7:0] + 8'd1];
    case (f3)
      3'd0: return {{24{b0[7]}}, b0};
      3'd4: return {24'h0, b0};
      3'd1: return {{16{b1[7]}}, b1, b0};
      3'd5: return {16'h0, b1, b0};
      default: return {mem[a[7:0] + 8'd3], mem[a[7:0] + 8'd2], b1, b0};
    endcase
  endfunction

  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input int d, input logic junk_ack, output logic [31:0] rd);
    int n;
    logic bad;
    logic [3:0] esel;
    logic [31:0] erd;
    n = nbytes(f3);
    bad = (we ? f3 > 3'd2 : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || (a % n) != 0;
    esel = 4'(((1 << n) - 1) << a[1:0]);
    erd = model_load(f3, a);
    junk = $urandom;
    @(negedge clk);
    chk("ready_idle", req_ready, 1'b1);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    rd = resp_rdata;
    if (bad) begin
      chk("err_resp", {resp_valid, resp_err, wb_cyc, wb_stb}, 4'b1100);
      chk("err_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      chk("err_after", {resp_valid, wb_cyc, req_ready}, 3'b001);
      return;
    end
    chk("strobe", {wb_cyc, wb_stb, wb_we, resp_valid}, {3'b110 | {2'b00, we}, 1'b0});
    chk("sel", wb_sel, esel);
    chk("adr", wb_adr, a);
    if (we) begin
      chk("dat_o", wb_dat_o, wd);
      for (int i = 0; i < n; i++) mem[a[7:0] + 8'(i)] = wd[8*i +: 8];
      wb_ack = junk_ack;
      @(negedge clk);
      wb_ack = 0;
      chk("st_resp", {resp_valid, resp_err, wb_cyc, wb_stb}, 4'b1000);
      chk("st_rdata", resp_rdata, 32'h0);
      return;
    end
    wb_ack = junk_ack && d > 0;
    @(negedge clk);
    for (int i = 0; i < d; i++) begin
      wb_ack = 0;
      chk("wait", {wb_cyc, wb_stb, resp_valid}, 3'b100);
      chk("wait_sel", wb_sel, esel);
      @(negedge clk);
    end
    chk("ack_hold", {wb_cyc, wb_stb, wb_sel}, {2'b10, esel});
    chk("ack_adr", wb_adr, a);
    wb_ack = 1;
    @(negedge clk);
    wb_ack = 0;
    chk("ld_resp", {resp_valid, resp_err, wb_cyc}, 3'b100);
    chk("ld_rdata", resp_rdata, erd);
    rd = resp_rdata;
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    int dmax;
`ifdef WB_LSU_TIMEOUT_EN
    dmax = 15;
`else
    dmax = 24;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_outs", {resp_valid, resp_err, wb_cyc, wb_stb, wb_we, wb_sel}, 9'h0);
    chk("rst_words", resp_rdata | wb_adr | wb_dat_o, 32'h0);
    rst_n = 1;
    for (int i = 0; i < 64; i++) xfer(1, 3'd2, {24'($urandom), 6'(i), 2'b00}, $urandom, 0, 0, got);
    xfer(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, got);
    xfer(1, 3'd0, 32'h13, 32'h000000A5, 0, 1, got);
    xfer(0, 3'd4, 32'h13, 0, 0, 0, got);
    chk("plan_lbu", got, 32'h000000A5);
    xfer(0, 3'd0, 32'h13, 0, 0, 0, got);
    chk("plan_lb", got, 32'hFFFFFFA5);
    xfer(1, 3'd2, 32'h10, 32'h80011234, 0, 0, got);
    xfer(0, 3'd1, 32'h12, 0, 2, 1, got);
    chk("plan_lh", got, 32'hFFFF8001);
    xfer(0, 3'd5, 32'h12, 0, 1, 0, got);
    chk("plan_lhu", got, 32'h00008001);
    xfer(0, 3'd2, 32'h06, 0, 0, 0, got);
    xfer(0, 3'd3, 32'h10, 0, 0, 0, got);
    xfer(1, 3'd4, 32'h10, 32'h1, 0, 0, got);
    // reset while a load sits in WAIT
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h20;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk("pre_rst_wait", {wb_cyc, wb_stb}, 2'b10);
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid", {wb_cyc, wb_stb, req_ready, resp_valid}, 4'b0010);
    rst_n = 1;
    wb_ack = 1;
    @(negedge clk);
    wb_ack = 0;
    chk("rst_no_resp", {resp_valid, wb_cyc, req_ready}, 3'b001);
`ifdef WB_LSU_TIMEOUT_EN
    @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h24;
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i < 16) chk("tmo_wait", {wb_cyc, resp_valid}, 2'b10);
    end
    chk("tmo_err", {resp_valid, resp_err, wb_cyc}, 3'b110);
    chk("tmo_rdata", resp_rdata, 32'h0);
    wb_ack = 1;
    @(negedge clk);
    wb_ack = 0;
    chk("tmo_late_ack", {resp_valid, wb_cyc, req_ready}, 3'b001);
`endif
    for (int k = 0; k < 300; k++) begin
      f3 = 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(f3) - 1);
      xfer(1'($urandom), f3, a, $urandom, $urandom_range(0, dmax), 1'($urandom), got);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
